ex_reg: RTL and testbench

- EX/MEM pipeline register, directly downstream of alu in the EX stage.
- Latches the alu result, the overflow flag and the decode fields forwarded from ID, and hands them to the MEM stage.
- Converts a signed ALU overflow into an overflow exception and suppresses the side effects of the faulting instruction.
- Honours the pipeline stall and flush requests from the control unit.

---
 rtl/ex_reg_pkg.sv | 49 ++++
 rtl/ex_ovf_cnt.sv | 24 ++
 rtl/ex_reg.sv | 92 +++++++++
 tb/tb_ex_reg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_reg_pkg.sv
// Shared EX/MEM stage types: memory-op and exception encodings, the latched field bundle
// and its bubble value.
package ex_reg_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int REG_ADDR_W  = 5;
    localparam int OVF_CNT_W   = 16;
    localparam int MEM_OP_W    = 2;
    localparam int EXP_CODE_W  = 3;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2
    } mem_op_e;

    typedef enum logic [EXP_CODE_W-1:0] {
        EXP_NO_EXP      = 3'd0,
        EXP_EXT_INT     = 3'd1,
        EXP_UNDEF_INSN  = 3'd2,
        EXP_OVERFLOW    = 3'd3,
        EXP_MISS_ALIGN  = 3'd4,
        EXP_TRAP        = 3'd5,
        EXP_PRV_VIOLATE = 3'd6
    } exp_code_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        mem_op_e                mem_op;
        logic [WORD_DATA_W-1:0] mem_wr_data;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        exp_code_e              exp_code;
        logic [WORD_DATA_W-1:0] out;
    } ex_fields_t;

    // A bubble has no side effects; it doubles as the reset value.
    function automatic ex_fields_t ex_bubble();
        ex_fields_t b;
        b             = '0;
        b.mem_op      = MEM_OP_NOP;
        b.gpr_we_     = 1'b1;
        b.exp_code    = EXP_NO_EXP;
        return b;
    endfunction

endpackage

// File: rtl/ex_ovf_cnt.sv
// Saturating overflow-event counter with synchronous clear (clear beats increment).
module ex_ovf_cnt
    import ex_reg_pkg::*;
#(
    parameter int W = OVF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_reg.sv
// EX/MEM pipeline register: latches ALU result and ID fields, turns ALU overflow into an
// exception. Define EX_OVF_CNT_EN to enable the overflow event counter on ovf_cnt.
module ex_reg
    import ex_reg_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_DATA_W-1:0] alu_out,
    input  logic                   alu_of,
    input  logic [WORD_ADDR_W-1:0] id_pc,
    input  logic                   id_en,
    input  logic [MEM_OP_W-1:0]    id_mem_op,
    input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
    input  logic [REG_ADDR_W-1:0]  id_dst_addr,
    input  logic                   id_gpr_we_,
    input  logic [EXP_CODE_W-1:0]  id_exp_code,
    input  logic                   stall,
    input  logic                   flush,
    output logic [WORD_ADDR_W-1:0] ex_pc,
    output logic                   ex_en,
    output logic [MEM_OP_W-1:0]    ex_mem_op,
    output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    output logic [REG_ADDR_W-1:0]  ex_dst_addr,
    output logic                   ex_gpr_we_,
    output logic [EXP_CODE_W-1:0]  ex_exp_code,
    output logic [WORD_DATA_W-1:0] ex_out,
    output logic [OVF_CNT_W-1:0]   ovf_cnt,
    input  logic                   ovf_cnt_clr
);

    ex_fields_t ex_q;
    ex_fields_t load_d;
    logic       ovf_event;

    // NOTE: every variable gets a default before the if-chain so no path infers a latch.
    always_comb begin
        load_d             = ex_bubble();
        load_d.pc          = id_pc;
        load_d.en          = id_en;
        load_d.mem_wr_data = id_mem_wr_data;
        load_d.dst_addr    = id_dst_addr;
        load_d.out         = alu_out;
        ovf_event          = 1'b0;
        if (id_en) begin
            // An exception from an earlier stage is older and masks the ALU overflow.
            if (id_exp_code != EXP_NO_EXP) begin
                load_d.exp_code = exp_code_e'(id_exp_code);
            end else if (alu_of) begin
                load_d.exp_code = EXP_OVERFLOW;
                ovf_event       = 1'b1;
            end else begin
                load_d.mem_op  = mem_op_e'(id_mem_op);
                load_d.gpr_we_ = id_gpr_we_;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q <= ex_bubble();
        end else if (!stall) begin
            ex_q <= flush ? ex_bubble() : load_d;
        end
    end

    assign ex_pc          = ex_q.pc;
    assign ex_en          = ex_q.en;
    assign ex_mem_op      = ex_q.mem_op;
    assign ex_mem_wr_data = ex_q.mem_wr_data;
    assign ex_dst_addr    = ex_q.dst_addr;
    assign ex_gpr_we_     = ex_q.gpr_we_;
    assign ex_exp_code    = ex_q.exp_code;
    assign ex_out         = ex_q.out;

`ifdef EX_OVF_CNT_EN
    ex_ovf_cnt #(
        .W(OVF_CNT_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ovf_cnt_clr),
        .inc   (ovf_event & ~stall & ~flush),
        .cnt   (ovf_cnt)
    );
`else
    logic unused_ovf;
    assign unused_ovf = ovf_cnt_clr ^ ovf_event;
    assign ovf_cnt    = '0;
`endif

endmodule

// File: tb/tb_ex_reg.sv
// Self-checking bench for ex_reg: directed test-plan cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_ex_reg;
    import ex_reg_pkg::*;

`ifdef EX_OVF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [WORD_DATA_W-1:0] alu_out;
    logic                   alu_of;
    logic [WORD_ADDR_W-1:0] id_pc;
    logic                   id_en;
    logic [MEM_OP_W-1:0]    id_mem_op;
    logic [WORD_DATA_W-1:0] id_mem_wr_data;
    logic [REG_ADDR_W-1:0]  id_dst_addr;
    logic                   id_gpr_we_;
    logic [EXP_CODE_W-1:0]  id_exp_code;
    logic                   stall;
    logic                   flush;
    logic                   ovf_cnt_clr;
    logic [WORD_ADDR_W-1:0] ex_pc;
    logic                   ex_en;
    logic [MEM_OP_W-1:0]    ex_mem_op;
    logic [WORD_DATA_W-1:0] ex_mem_wr_data;
    logic [REG_ADDR_W-1:0]  ex_dst_addr;
    logic                   ex_gpr_we_;
    logic [EXP_CODE_W-1:0]  ex_exp_code;
    logic [WORD_DATA_W-1:0] ex_out;
    logic [OVF_CNT_W-1:0]   ovf_cnt;

    ex_reg dut (
        .clk            (clk),
        .reset          (reset),
        .alu_out        (alu_out),
        .alu_of         (alu_of),
        .id_pc          (id_pc),
        .id_en          (id_en),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_exp_code    (id_exp_code),
        .stall          (stall),
        .flush          (flush),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .ovf_cnt        (ovf_cnt),
        .ovf_cnt_clr    (ovf_cnt_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected register contents, as the outputs should look after the most recent edge.
    typedef struct {
        int unsigned pc;
        bit          en;
        int unsigned mem_op;
        int unsigned wd;
        int unsigned dst;
        bit          we_;
        int unsigned exc;
        int unsigned out;
        int unsigned cnt;
    } mdl_t;

    mdl_t mdl;
    bit   mdl_valid = 1'b0;

    function automatic mdl_t idle_state(input int unsigned cnt);
        mdl_t r;
        r = '{pc: 0, en: 0, mem_op: 0, wd: 0, dst: 0, we_: 1, exc: 0, out: 0, cnt: cnt};
        return r;
    endfunction

    function automatic mdl_t next_model(input mdl_t m);
        mdl_t        n;
        int unsigned exc;
        bit          clean;
        if (!reset) return idle_state(0);
        n = m;
        // Exception the instruction would carry: older ID exception first, then ALU overflow.
        if (!id_en)                   exc = 0;
        else if (id_exp_code != 0)    exc = id_exp_code;
        else if (alu_of)              exc = 3;
        else                          exc = 0;
        clean = id_en && (exc == 0);
        if (!stall) begin
            if (flush) begin
                n = idle_state(m.cnt);
            end else begin
                n.pc     = id_pc;
                n.en     = id_en;
                n.wd     = id_mem_wr_data;
                n.dst    = id_dst_addr;
                n.out    = alu_out;
                n.exc    = exc;
                n.mem_op = clean ? id_mem_op : 0;
                n.we_    = clean ? id_gpr_we_ : 1'b1;
            end
        end
        if (ovf_cnt_clr)
            n.cnt = 0;
        else if (!stall && !flush && id_en && id_exp_code == 0 && alu_of && m.cnt < 65535)
            n.cnt = m.cnt + 1;
        return n;
    endfunction

    always @(posedge clk) begin
        mdl = next_model(mdl);
        if (!reset) mdl_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("pc",      64'(ex_pc),          64'(mdl.pc[WORD_ADDR_W-1:0]));
            check("en",      64'(ex_en),          64'(mdl.en));
            check("mem_op",  64'(ex_mem_op),      64'(mdl.mem_op));
            check("wr_data", 64'(ex_mem_wr_data), 64'(mdl.wd));
            check("dst",     64'(ex_dst_addr),    64'(mdl.dst));
            check("gpr_we_", 64'(ex_gpr_we_),     64'(mdl.we_));
            check("exp",     64'(ex_exp_code),    64'(mdl.exc));
            check("out",     64'(ex_out),         64'(mdl.out));
            check("ovf_cnt", 64'(ovf_cnt),        CNT_ON ? 64'(mdl.cnt) : 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        logic [EXP_CODE_W-1:0] codes [5];
        codes          = '{EXP_EXT_INT, EXP_UNDEF_INSN, EXP_MISS_ALIGN, EXP_TRAP, EXP_PRV_VIOLATE};
        alu_out        = $urandom;
        alu_of         = ($urandom_range(0, 2) == 0);
        id_pc          = WORD_ADDR_W'($urandom);
        id_en          = ($urandom_range(0, 3) != 0);
        id_mem_op      = MEM_OP_W'($urandom_range(0, 2));
        id_mem_wr_data = $urandom;
        id_dst_addr    = REG_ADDR_W'($urandom);
        id_gpr_we_     = 1'($urandom);
        id_exp_code    = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 4)] : EXP_NO_EXP;
        stall          = ($urandom_range(0, 4) == 0);
        flush          = ($urandom_range(0, 9) == 0);
        ovf_cnt_clr    = ($urandom_range(0, 19) == 0);
        reset          = ($urandom_range(0, 49) != 0);
    endtask

    initial begin
        reset = 1'b0; alu_out = '0; alu_of = 1'b0; id_pc = '0; id_en = 1'b0;
        id_mem_op = MEM_OP_NOP; id_mem_wr_data = '0; id_dst_addr = '0; id_gpr_we_ = 1'b1;
        id_exp_code = EXP_NO_EXP; stall = 1'b0; flush = 1'b0; ovf_cnt_clr = 1'b0;
        cyc();
        cyc();
        check("rst_en",      64'(ex_en),       64'd0);
        check("rst_we_",     64'(ex_gpr_we_),  64'd1);
        check("rst_mem_op",  64'(ex_mem_op),   64'(MEM_OP_NOP));
        check("rst_exp",     64'(ex_exp_code), 64'(EXP_NO_EXP));
        check("rst_cnt",     64'(ovf_cnt),     64'd0);

        // Plain load.
        reset = 1'b1; id_en = 1'b1; alu_out = 32'h0506_0507; id_gpr_we_ = 1'b0;
        id_dst_addr = 5'd3; id_pc = 30'h100;
        cyc();
        check("t1_out",  64'(ex_out),      64'h0506_0507);
        check("t1_we_",  64'(ex_gpr_we_),  64'd0);
        check("t1_dst",  64'(ex_dst_addr), 64'd3);
        check("t1_exp",  64'(ex_exp_code), 64'(EXP_NO_EXP));

        // ALU overflow on a store that also writes a GPR.
        alu_out = 32'hffff_fffe; alu_of = 1'b1; id_mem_op = MEM_OP_STW;
        cyc();
        check("t2_exp",  64'(ex_exp_code), 64'(EXP_OVERFLOW));
        check("t2_we_",  64'(ex_gpr_we_),  64'd1);
        check("t2_mem",  64'(ex_mem_op),   64'(MEM_OP_NOP));
        check("t2_out",  64'(ex_out),      64'hffff_fffe);
        check("t2_cnt",  64'(ovf_cnt),     CNT_ON ? 64'd1 : 64'd0);

        // Stall holds for three cycles, then the new value lands.
        alu_of = 1'b0; stall = 1'b1; alu_out = 32'hdead_beef;
        repeat (3) cyc();
        check("t3_hold", 64'(ex_out),      64'hffff_fffe);
        check("t3_hexp", 64'(ex_exp_code), 64'(EXP_OVERFLOW));
        stall = 1'b0;
        cyc();
        check("t3_out",  64'(ex_out),      64'hdead_beef);
        check("t3_mem",  64'(ex_mem_op),   64'(MEM_OP_STW));

        // Flush makes a bubble; stall beats flush.
        flush = 1'b1;
        cyc();
        check("t4_en",   64'(ex_en),       64'd0);
        check("t4_mem",  64'(ex_mem_op),   64'(MEM_OP_NOP));
        check("t4_we_",  64'(ex_gpr_we_),  64'd1);
        flush = 1'b0; alu_out = 32'h11;
        cyc();
        stall = 1'b1; flush = 1'b1; alu_out = 32'h22;
        cyc();
        check("t4_sf_out", 64'(ex_out),    64'h11);
        check("t4_sf_en",  64'(ex_en),     64'd1);

        // Older exception masks overflow; invalid entry ignores overflow.
        stall = 1'b0; flush = 1'b0; id_exp_code = EXP_UNDEF_INSN; alu_of = 1'b1;
        cyc();
        check("t5_exp",  64'(ex_exp_code), 64'(EXP_UNDEF_INSN));
        check("t5_we_",  64'(ex_gpr_we_),  64'd1);
        check("t5_cnt",  64'(ovf_cnt),     CNT_ON ? 64'd1 : 64'd0);
        id_en = 1'b0; id_exp_code = EXP_NO_EXP;
        cyc();
        check("t5_iexp", 64'(ex_exp_code), 64'(EXP_NO_EXP));
        check("t5_ien",  64'(ex_en),       64'd0);

        // Reset beats stall with valid data present.
        id_en = 1'b1; alu_out = 32'h1234; stall = 1'b1; reset = 1'b0; alu_of = 1'b0;
        cyc();
        check("t6_out",  64'(ex_out),      64'd0);
        check("t6_pc",   64'(ex_pc),       64'd0);
        check("t6_we_",  64'(ex_gpr_we_),  64'd1);
        reset = 1'b1; stall = 1'b0;

        if (CNT_ON) begin
            alu_of = 1'b1;
            repeat (65535) cyc();
            check("t6_sat", 64'(ovf_cnt), 64'hffff);
            cyc();
            check("t6_sat_hold", 64'(ovf_cnt), 64'hffff);
            ovf_cnt_clr = 1'b1;
            cyc();
            check("t6_clr", 64'(ovf_cnt), 64'd0);
            ovf_cnt_clr = 1'b0;
        end

        repeat (3000) begin
            rand_inputs();
            cyc();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
